// File: rtl/sap_control_sequencer.sv
// ============================================================================
// Module  : sap_control_sequencer
// Brief   : Microcoded fetch/execute control unit for the 8-bit SAP computer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sap_control_sequencer (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [3:0]  opcode,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        carry_flag,
  output logic        zero_flag,
  output logic        halted
);

  localparam logic [15:0] c_HLT = 16'h0001;
  localparam logic [15:0] c_MI  = 16'h0002;
  localparam logic [15:0] c_RI  = 16'h0004;
  localparam logic [15:0] c_RO  = 16'h0008;
  localparam logic [15:0] c_IO  = 16'h0010;
  localparam logic [15:0] c_II  = 16'h0020;
  localparam logic [15:0] c_AI  = 16'h0040;
  localparam logic [15:0] c_AO  = 16'h0080;
  localparam logic [15:0] c_EO  = 16'h0100;
  localparam logic [15:0] c_SU  = 16'h0200;
  localparam logic [15:0] c_BI  = 16'h0400;
  localparam logic [15:0] c_OI  = 16'h0800;
  localparam logic [15:0] c_CE  = 16'h1000;
  localparam logic [15:0] c_CO  = 16'h2000;
  localparam logic [15:0] c_J   = 16'h4000;
  localparam logic [15:0] c_FI  = 16'h8000;

  localparam logic [3:0] c_OP_NOP = 4'h0;
  localparam logic [3:0] c_OP_LDA = 4'h1;
  localparam logic [3:0] c_OP_ADD = 4'h2;
  localparam logic [3:0] c_OP_SUB = 4'h3;
  localparam logic [3:0] c_OP_STA = 4'h4;
  localparam logic [3:0] c_OP_LDI = 4'h5;
  localparam logic [3:0] c_OP_JMP = 4'h6;
  localparam logic [3:0] c_OP_JC  = 4'h7;
  localparam logic [3:0] c_OP_JZ  = 4'h8;
  localparam logic [3:0] c_OP_OUT = 4'he;
  localparam logic [3:0] c_OP_HLT = 4'hf;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  step_t       r_step;
  step_t       w_step_nxt;
  logic        r_cf;
  logic        r_zf;
  logic        r_halted;
  logic [15:0] w_ctrl;
  logic        w_last;
  logic        w_halt_now;
  logic        w_fi;

  // Microcode decode: control word plus "this is the instruction's last step".
  always_comb begin
    w_ctrl = '0;
    w_last = 1'b0;
    case (r_step)
      T0: w_ctrl = c_CO | c_MI;
      T1: begin
        w_ctrl = c_RO | c_II | c_CE;
        w_last = (opcode == c_OP_NOP) || ((opcode >= 4'h9) && (opcode <= 4'hd));
      end
      T2: begin
        w_last = 1'b1;
        case (opcode)
          c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
            w_ctrl = c_IO | c_MI;
            w_last = 1'b0;
          end
          c_OP_LDI: w_ctrl = c_IO | c_AI;
          c_OP_JMP: w_ctrl = c_IO | c_J;
          c_OP_JC:  w_ctrl = c_IO | (r_cf ? c_J : 16'h0000);
          c_OP_JZ:  w_ctrl = c_IO | (r_zf ? c_J : 16'h0000);
          c_OP_OUT: w_ctrl = c_AO | c_OI;
          c_OP_HLT: w_ctrl = c_HLT;
          default:  w_ctrl = '0;
        endcase
      end
      T3: begin
        w_last = 1'b1;
        case (opcode)
          c_OP_LDA: w_ctrl = c_RO | c_AI;
          c_OP_ADD, c_OP_SUB: begin
            w_ctrl = c_RO | c_BI;
            w_last = 1'b0;
          end
          c_OP_STA: w_ctrl = c_AO | c_RI;
          default:  w_ctrl = '0;
        endcase
      end
      T4: begin
        w_last = 1'b1;
        if (opcode == c_OP_ADD)      w_ctrl = c_EO | c_AI | c_FI;
        else if (opcode == c_OP_SUB) w_ctrl = c_EO | c_AI | c_FI | c_SU;
      end
      default: w_last = 1'b1;
    endcase
  end

  assign w_halt_now = (r_step == T2) && (opcode == c_OP_HLT) && !r_halted;
  assign w_fi       = w_ctrl[15] && !r_halted;

  // HLT keeps the step parked at T2 rather than wrapping to T0.
  always_comb begin
    w_step_nxt = r_step;
    if (r_step > T4)
      w_step_nxt = T0;
    else if (r_halted || w_halt_now)
      w_step_nxt = r_step;
    else if (w_last)
      w_step_nxt = T0;
    else
      w_step_nxt = step_t'(r_step + 3'd1);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_step   <= T0;
      r_cf     <= 1'b0;
      r_zf     <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_step <= w_step_nxt;
      if (w_halt_now)
        r_halted <= 1'b1;
      if (w_fi) begin
        r_cf <= alu_carry;
        r_zf <= alu_zero;
      end
    end
  end

  assign ctrl       = !clr_n ? 16'h0000 : (r_halted ? c_HLT : w_ctrl);
  assign step       = r_step;
  assign carry_flag = r_cf;
  assign zero_flag  = r_zf;
  assign halted     = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_sap_control_sequencer.sv
// ============================================================================
// Module  : tb_sap_control_sequencer
// Brief   : Randomized self-checking bench against an instruction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sap_control_sequencer;

  logic        clk;
  logic        clr_n;
  logic [3:0]  opcode;
  logic        alu_carry;
  logic        alu_zero;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        carry_flag;
  logic        zero_flag;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model state
  bit m_cf = 1'b0;
  bit m_zf = 1'b0;

  sap_control_sequencer dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .opcode     (opcode),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .ctrl       (ctrl),
    .step       (step),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full micro-program of one instruction as a list of control words.
  task automatic build_prog(input logic [3:0] op, output logic [15:0] prog[$]);
    prog = {16'h2002, 16'h1028};
    case (op)
      4'h1: prog = {prog, 16'h0012, 16'h0048};
      4'h2: prog = {prog, 16'h0012, 16'h0408, 16'h8140};
      4'h3: prog = {prog, 16'h0012, 16'h0408, 16'h8340};
      4'h4: prog = {prog, 16'h0012, 16'h0084};
      4'h5: prog = {prog, 16'h0050};
      4'h6: prog = {prog, 16'h4010};
      4'h7: prog = {prog, m_cf ? 16'h4010 : 16'h0010};
      4'h8: prog = {prog, m_zf ? 16'h4010 : 16'h0010};
      4'he: prog = {prog, 16'h0880};
      4'hf: prog = {prog, 16'h0001};
      default: ;
    endcase
  endtask

  // Entered just after a rising edge with the DUT at T0.
  task automatic run_instr(input logic [3:0] op, input bit car, input bit zer);
    logic [15:0] prog[$];
    build_prog(op, prog);
    for (int i = 0; i < prog.size(); i++) begin
      opcode    = op;
      alu_carry = car;
      alu_zero  = zer;
      #1;
      chk($sformatf("ctrl op%0h s%0d", op, i), {16'h0, ctrl}, {16'h0, prog[i]});
      chk($sformatf("step op%0h s%0d", op, i), {29'h0, step}, i);
      chk("halted", {31'h0, halted}, 0);
      @(posedge clk);
      #1;
    end
    if (op == 4'h2 || op == 4'h3) begin
      m_cf = car;
      m_zf = zer;
    end
    chk($sformatf("cf after op%0h", op), {31'h0, carry_flag}, {31'h0, m_cf});
    chk($sformatf("zf after op%0h", op), {31'h0, zero_flag}, {31'h0, m_zf});
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " ctrl"},   {16'h0, ctrl},       0);
    chk({tag, " step"},   {29'h0, step},       0);
    chk({tag, " cf"},     {31'h0, carry_flag}, 0);
    chk({tag, " zf"},     {31'h0, zero_flag},  0);
    chk({tag, " halted"}, {31'h0, halted},     0);
  endtask

  initial begin
    clr_n     = 1'b0;
    opcode    = 4'h0;
    alu_carry = 1'b0;
    alu_zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    clr_n = 1'b1;
    #1;
    chk("release ctrl", {16'h0, ctrl}, 32'h2002);
    @(posedge clk);
    #1;
    chk("first T1 ctrl", {16'h0, ctrl}, 32'h1028);
    chk("first T1 step", {29'h0, step}, 1);
    @(posedge clk);
    #1;

    // Directed program
    run_instr(4'h7, 1'b1, 1'b1);
    run_instr(4'h1, 1'b1, 1'b1);
    run_instr(4'h2, 1'b1, 1'b0);
    run_instr(4'h7, 1'b0, 1'b0);
    run_instr(4'h3, 1'b0, 1'b1);
    run_instr(4'h8, 1'b0, 1'b0);
    run_instr(4'hb, 1'b1, 1'b1);

    // Reset in the middle of an ADD at T3
    for (int i = 0; i < 4; i++) begin
      opcode    = 4'h2;
      alu_carry = 1'b1;
      alu_zero  = 1'b1;
      #1;
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    chk("midadd T3 step", {29'h0, step}, 3);
    clr_n = 1'b0;
    #1;
    check_reset_state("midadd rst");
    m_cf = 1'b0;
    m_zf = 1'b0;
    clr_n = 1'b1;
    #1;
    chk("midadd release ctrl", {16'h0, ctrl}, 32'h2002);

    // Random instruction stream, HLT excluded until the end
    for (int n = 0; n < 80; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      run_instr(op, 1'($urandom), 1'($urandom));
    end

    // HLT: freeze
    run_instr(4'hf, 1'($urandom), 1'($urandom));
    chk("halt set", {31'h0, halted}, 1);
    for (int n = 0; n < 10; n++) begin
      opcode    = 4'($urandom);
      alu_carry = 1'($urandom);
      alu_zero  = 1'($urandom);
      @(posedge clk);
      #1;
      chk("halt step", {29'h0, step}, 2);
      chk("halt ctrl", {16'h0, ctrl}, 32'h0001);
      chk("halt cf",   {31'h0, carry_flag}, {31'h0, m_cf});
      chk("halt zf",   {31'h0, zero_flag},  {31'h0, m_zf});
      chk("halt held", {31'h0, halted},     1);
    end
    clr_n = 1'b0;
    #1;
    check_reset_state("halt rst");
    m_cf  = 1'b0;
    m_zf  = 1'b0;
    clr_n = 1'b1;
    #1;
    run_instr(4'h5, 1'b0, 1'b0);
    run_instr(4'he, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
